branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor that replaces the pipeline's fixed "always not taken" policy. It is a direct-mapped branch target buffer with per-entry saturating counters, looked up combinationally by the fetch stage and trained by the execute stage on every resolved branch or jump. It also keeps lookup and mispredict statistics for performance evaluation.

## Interface
- ENTRIES, 64: number of table entries. Power of two, ≥2. IDX_BITS = log2(ENTRIES).
- TAG_BITS, 8: stored tag width. Requires IDX_BITS+2+TAG_BITS ≤ 32.
- CNT_BITS, 2: saturating counter width, ≥1.
- clk  in  1  clock. All state updates occur on the falling edge, in step with the pipeline stage registers.
- reset  in  1  synchronous, active-high. Sampled on the clk falling edge.
- lookup_valid  in  1  fetch is advancing this cycle (not stalled).
- lookup_pc  in  32  PC being fetched.
- predict_hit  out  1  valid entry with matching tag exists for lookup_pc.
- predict_taken  out  1  hit and counter MSB = 1.
- predict_target  out  32  stored target if predict_taken, else lookup_pc+4.
- update_valid  in  1  execute has resolved a branch or jump this cycle.
- update_pc  in  32  PC of the resolved instruction.
- update_taken  in  1  actual outcome.
- update_target  in  32  actual taken target.
- update_force_jump  in  1  unconditional jump.
- update_mispredict  in  1  prediction carried down the pipe was wrong.
- stat_lookups  out  32  count of cycles with lookup_valid.
- stat_mispredicts  out  32  count of updates with update_mispredict.

## Operation
- Index = pc[IDX_BITS+1:2]. Tag = pc[IDX_BITS+1+TAG_BITS : IDX_BITS+2]. pc[1:0] ignored.
- Entry fields: valid, tag, target[31:0], cnt[CNT_BITS-1:0].
- Lookup is purely combinational from lookup_pc and current table contents. predict_* depend only on lookup_pc, not on lookup_valid.
- Update when update_valid is high, indexed by update_pc:
  - Hit, update_force_jump: cnt ← all ones, target ← update_target.
  - Hit, conditional taken: cnt ← min(cnt+1, max), target ← update_target.
  - Hit, not taken: cnt ← max(cnt-1, 0). Target is unchanged.
  - Miss, taken or force_jump: allocate and replace any existing entry. Set valid=1, tag, target. cnt = all ones if force_jump, else weakly taken (1<<(CNT_BITS-1)).
  - Miss, not taken: no allocation. Table is unchanged.
- Statistics:
  - stat_lookups increments on each edge with lookup_valid.
  - stat_mispredicts increments on each edge with update_valid && update_mispredict.
  - Both wrap modulo 2^32.
  - update_mispredict without update_valid is ignored.

## Timing
- Lookup latency is 0 cycles (combinational). Update becomes visible to lookups after the next falling edge.
- Simultaneous lookup and update to the same index: the lookup in that cycle sees pre-update contents. There is no bypass.
- Reset:
  - All valid bits, counters and targets are cleared, and both stat counters go to 0.
  - While reset is high, predict_hit=0 and predict_taken=0, and predict_target=lookup_pc+4.
  - Updates and statistics increments are suppressed in any cycle reset is high, including reset asserted mid-operation.
- Counter arithmetic saturates. It never wraps.
- Target arithmetic lookup_pc+4 wraps modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).
- There is no stall or handshake output. Table writes always complete in one cycle.

## Test plan
(ENTRIES=64, TAG_BITS=8, CNT_BITS=2 unless noted.)
- Reset, then lookup_pc=0x0000_0040 → hit=0, taken=0, target=0x0000_0044, stat_lookups/stat_mispredicts=0.
- Conditional taken update on pc=0x40 with target=0x100 → next cycle lookup 0x40 gives hit=1, taken=1, target=0x100, cnt=2.
- Not-taken updates on 0x40:
  - After the first (cnt=1): taken=0, target=0x44.
  - After the second: cnt=0, and it stays 0 on a third.
- Saturation: four taken updates on a fresh pc=0x80 → cnt goes 2,3,3,3.
- Force jump on a miss at 0x200 → cnt=3.
- Aliasing: 0x140 shares index 0x10 with 0x40 but has a different tag.
  - Lookup 0x140 → hit=0.
  - A taken update on 0x140 replaces the entry, after which lookup 0x40 → hit=0.
  - A not-taken update on an alias leaves the entry intact.
- Same-cycle lookup and update on 0x40 → the old prediction is shown that cycle and the new one the next.
- Reset asserted mid-stream after 10 lookups and 3 mispredicts → all stats=0 and all lookups miss.
- stat_mispredicts preloaded to 0xFFFF_FFFF (by forcing), then one mispredict → 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/execute side of the branch predictor: lookup request, prediction and statistics bundle.
// Ports: lookup_valid/lookup_pc in, predict_hit/taken/target out, update_* in, stat_* out.
// master = pipeline (fetch + execute) side, slave = predictor side.
interface branch_predictor_if;
   logic        lookup_valid;
   logic [31:0] lookup_pc;
   logic        predict_hit;
   logic        predict_taken;
   logic [31:0] predict_target;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic        update_force_jump;
   logic        update_mispredict;
   logic [31:0] stat_lookups;
   logic [31:0] stat_mispredicts;

   modport master (
      output lookup_valid, lookup_pc,
      output update_valid, update_pc, update_taken, update_target,
      output update_force_jump, update_mispredict,
      input  predict_hit, predict_taken, predict_target,
      input  stat_lookups, stat_mispredicts
   );

   modport slave (
      input  lookup_valid, lookup_pc,
      input  update_valid, update_pc, update_taken, update_target,
      input  update_force_jump, update_mispredict,
      output predict_hit, predict_taken, predict_target,
      output stat_lookups, stat_mispredicts
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating counters plus lookup/mispredict statistics.
// Ports: clk, reset (sync, active-high, falling edge), bp (slave modport of branch_predictor_if).
// Lookup is combinational (0 cycles); training and statistics commit on the falling edge; never stalls.
module branch_predictor #(
   parameter int ENTRIES  = 64,
   parameter int TAG_BITS = 8,
   parameter int CNT_BITS = 2
) (
   input  logic               clk,
   input  logic               reset,
   branch_predictor_if.slave  bp
);
   localparam int IDX_BITS = $clog2(ENTRIES);
   localparam int TAG_LO   = IDX_BITS + 2;
   localparam int TAG_HI   = IDX_BITS + 1 + TAG_BITS;
   localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
   localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1) << (CNT_BITS - 1);

   logic                r_valid  [ENTRIES];
   logic [TAG_BITS-1:0] r_tag    [ENTRIES];
   logic [31:0]         r_target [ENTRIES];
   logic [CNT_BITS-1:0] r_cnt    [ENTRIES];
   logic [31:0]         r_stat_lookups;
   logic [31:0]         r_stat_mispredicts;

   logic [IDX_BITS-1:0] w_lk_idx;
   logic [TAG_BITS-1:0] w_lk_tag;
   logic                w_lk_hit;
   logic                w_lk_taken;
   logic [IDX_BITS-1:0] w_up_idx;
   logic [TAG_BITS-1:0] w_up_tag;
   logic                w_up_hit;
   logic                w_unused;

   assign w_lk_idx = bp.lookup_pc[IDX_BITS+1:2];
   assign w_lk_tag = bp.lookup_pc[TAG_HI:TAG_LO];
   assign w_up_idx = bp.update_pc[IDX_BITS+1:2];
   assign w_up_tag = bp.update_pc[TAG_HI:TAG_LO];
   // Low and high PC bits of the update address never reach the table.
   assign w_unused = ^bp.update_pc;

   // Reset gates the hit so predictions stay "fall through" while the table is being cleared.
   assign w_lk_hit   = !reset && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
   assign w_lk_taken = w_lk_hit && r_cnt[w_lk_idx][CNT_BITS-1];
   assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

   assign bp.predict_hit      = w_lk_hit;
   assign bp.predict_taken    = w_lk_taken;
   assign bp.predict_target   = w_lk_taken ? r_target[w_lk_idx] : bp.lookup_pc + 32'd4;
   assign bp.stat_lookups     = r_stat_lookups;
   assign bp.stat_mispredicts = r_stat_mispredicts;

   // Falling edge keeps table writes in step with the pipeline stage registers.
   always_ff @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_cnt[i]    <= '0;
         end
         r_stat_lookups     <= '0;
         r_stat_mispredicts <= '0;
      end else begin
         if (bp.lookup_valid)
            r_stat_lookups <= r_stat_lookups + 32'd1;
         if (bp.update_valid && bp.update_mispredict)
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;

         if (bp.update_valid) begin
            if (w_up_hit) begin
               if (bp.update_force_jump) begin
                  r_cnt[w_up_idx]    <= CNT_MAX;
                  r_target[w_up_idx] <= bp.update_target;
               end else if (bp.update_taken) begin
                  if (r_cnt[w_up_idx] != CNT_MAX)
                     r_cnt[w_up_idx] <= r_cnt[w_up_idx] + CNT_BITS'(1);
                  r_target[w_up_idx] <= bp.update_target;
               end else if (r_cnt[w_up_idx] != '0) begin
                  r_cnt[w_up_idx] <= r_cnt[w_up_idx] - CNT_BITS'(1);
               end
            end else if (bp.update_taken || bp.update_force_jump) begin
               // Allocation evicts whatever alias currently owns the slot.
               r_valid[w_up_idx]  <= 1'b1;
               r_tag[w_up_idx]    <= w_up_tag;
               r_target[w_up_idx] <= bp.update_target;
               r_cnt[w_up_idx]    <= bp.update_force_jump ? CNT_MAX : CNT_WEAK;
            end
         end
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   branch_predictor_if bp ();
   branch_predictor #(.ENTRIES(64), .TAG_BITS(8), .CNT_BITS(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bp    (bp)
   );

   typedef struct {
      string       name;
      logic        lv;
      logic [31:0] lpc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic        uf;
      logic        um;
      logic        eh;
      logic        et;
      logic [31:0] etgt;
      logic        ck;
      int          cidx;
      logic [1:0]  ecnt;
   } vec_t;

   typedef struct {
      string       name;
      logic        hit;
      logic        taken;
      logic [31:0] tgt;
   } exp_t;

   exp_t        sb_q[$];
   vec_t        tbl[22];
   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] exp_lk = 0;
   logic [31:0] exp_mp = 0;

   function automatic vec_t mk(input string name, input logic lv, input logic [31:0] lpc,
                               input logic uv, input logic [31:0] upc, input logic ut,
                               input logic [31:0] utgt, input logic uf, input logic um,
                               input logic eh, input logic et, input logic [31:0] etgt,
                               input logic ck, input int cidx, input logic [1:0] ecnt);
      vec_t v;
      v.name = name; v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut;
      v.utgt = utgt; v.uf = uf; v.um = um; v.eh = eh; v.et = et; v.etgt = etgt;
      v.ck = ck; v.cidx = cidx; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle, queue its expected prediction, compare mid-cycle, then let the falling edge commit.
   task automatic step(input vec_t v);
      exp_t e;
      @(posedge clk);
      bp.lookup_valid      = v.lv;
      bp.lookup_pc         = v.lpc;
      bp.update_valid      = v.uv;
      bp.update_pc         = v.upc;
      bp.update_taken      = v.ut;
      bp.update_target     = v.utgt;
      bp.update_force_jump = v.uf;
      bp.update_mispredict = v.um;
      sb_q.push_back('{v.name, v.eh, v.et, v.etgt});
      if (!reset) begin
         if (v.lv) exp_lk = exp_lk + 1;
         if (v.uv && v.um) exp_mp = exp_mp + 1;
      end
      #1;
      if (sb_q.size() == 0) begin
         chk({v.name, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk({e.name, "_hit"}, 32'(bp.predict_hit), 32'(e.hit));
         chk({e.name, "_taken"}, 32'(bp.predict_taken), 32'(e.taken));
         chk({e.name, "_target"}, bp.predict_target, e.tgt);
      end
      @(negedge clk);
      #1;
      if (v.ck) chk({v.name, "_cnt"}, 32'(dut.r_cnt[v.cidx]), 32'(v.ecnt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset phase: an attempted update and mispredict must be suppressed.
      repeat (2) @(negedge clk);
      step(mk("rst_hold", 1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 1, 0, 0, 32'h44, 0, 0, 0));
      reset = 1'b0;
      step(mk("rst_lookup", 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 32'h44, 0, 0, 0));
      chk("rst_stat_lookups", bp.stat_lookups, 32'd0);
      chk("rst_stat_mispredicts", bp.stat_mispredicts, 32'd0);

      // Index 0x10: 0x40 (tag 0) and 0x140 (tag 1). 0x80 -> idx 0x20. 0x200 -> idx 0, tag 2.
      tbl[0]  = mk("t_alloc",     1, 32'h40,  1, 32'h40,  1, 32'h100, 0, 1, 0, 0, 32'h44,  1, 16, 2);
      tbl[1]  = mk("t_hit",       1, 32'h40,  0, 0,       0, 0,       0, 0, 1, 1, 32'h100, 0, 0,  0);
      tbl[2]  = mk("t_nt1_same",  1, 32'h40,  1, 32'h40,  0, 32'h999, 0, 1, 1, 1, 32'h100, 1, 16, 1);
      tbl[3]  = mk("t_nt2",       1, 32'h40,  1, 32'h40,  0, 0,       0, 0, 1, 0, 32'h44,  1, 16, 0);
      tbl[4]  = mk("t_nt3_floor", 1, 32'h40,  1, 32'h40,  0, 0,       0, 0, 1, 0, 32'h44,  1, 16, 0);
      tbl[5]  = mk("t_sat1",      1, 32'h80,  1, 32'h80,  1, 32'h300, 0, 1, 0, 0, 32'h84,  1, 32, 2);
      tbl[6]  = mk("t_sat2",      1, 32'h80,  1, 32'h80,  1, 32'h304, 0, 0, 1, 1, 32'h300, 1, 32, 3);
      tbl[7]  = mk("t_sat3",      1, 32'h80,  1, 32'h80,  1, 32'h308, 0, 0, 1, 1, 32'h304, 1, 32, 3);
      tbl[8]  = mk("t_sat4",      1, 32'h80,  1, 32'h80,  1, 32'h30C, 0, 0, 1, 1, 32'h308, 1, 32, 3);
      tbl[9]  = mk("t_sat_dec",   1, 32'h80,  1, 32'h80,  0, 0,       0, 1, 1, 1, 32'h30C, 1, 32, 2);
      tbl[10] = mk("t_nolv",      0, 32'h80,  0, 0,       0, 0,       0, 0, 1, 1, 32'h30C, 0, 0,  0);
      tbl[11] = mk("t_fj_alloc",  1, 32'h200, 1, 32'h200, 0, 32'h1000,1, 1, 0, 0, 32'h204, 1, 0,  3);
      tbl[12] = mk("t_fj_dec",    1, 32'h200, 1, 32'h200, 0, 0,       0, 0, 1, 1, 32'h1000,1, 0,  2);
      tbl[13] = mk("t_fj_still",  1, 32'h200, 0, 0,       0, 0,       0, 0, 1, 1, 32'h1000,0, 0,  0);
      tbl[14] = mk("t_alias_nt",  1, 32'h140, 1, 32'h140, 0, 32'h777, 0, 0, 0, 0, 32'h144, 1, 16, 0);
      tbl[15] = mk("t_alias_kept",1, 32'h40,  0, 0,       0, 0,       0, 0, 1, 0, 32'h44,  0, 0,  0);
      tbl[16] = mk("t_alias_tk",  1, 32'h140, 1, 32'h140, 1, 32'h500, 0, 1, 0, 0, 32'h144, 1, 16, 2);
      tbl[17] = mk("t_evicted",   1, 32'h40,  0, 0,       0, 0,       0, 1, 0, 0, 32'h44,  0, 0,  0);
      tbl[18] = mk("t_alias_hit", 1, 32'h140, 0, 0,       0, 0,       0, 0, 1, 1, 32'h500, 0, 0,  0);
      tbl[19] = mk("t_pc_wrap",   1, 32'hFFFF_FFFC, 0, 0, 0, 0,       0, 0, 0, 0, 32'h0,   0, 0,  0);
      tbl[20] = mk("t_fj_hit",    1, 32'h140, 1, 32'h140, 1, 32'h600, 1, 0, 1, 1, 32'h500, 1, 16, 3);
      tbl[21] = mk("t_fj_newtgt", 1, 32'h140, 0, 0,       0, 0,       0, 0, 1, 1, 32'h600, 0, 0,  0);
      for (int i = 0; i < 22; i++) step(tbl[i]);
      chk("tbl_stat_lookups", bp.stat_lookups, exp_lk);
      chk("tbl_stat_mispredicts", bp.stat_mispredicts, exp_mp);

      // Mid-stream reset after 10 lookups and 3 mispredicts.
      exp_lk = 0;
      exp_mp = 0;
      reset = 1'b1;
      step(mk("mid_rst0", 0, 32'h140, 0, 0, 0, 0, 0, 0, 0, 0, 32'h144, 0, 0, 0));
      reset = 1'b0;
      for (int i = 0; i < 10; i++)
         step(mk("mid_lk", 1, 32'h144, (i < 3), 32'h400, 0, 0, 0, 1, 0, 0, 32'h148, 0, 0, 0));
      chk("mid_pre_lookups", bp.stat_lookups, 32'd10);
      chk("mid_pre_mispredicts", bp.stat_mispredicts, 32'd3);
      step(mk("mid_fill", 1, 32'h140, 1, 32'h140, 1, 32'h700, 0, 0, 0, 0, 32'h144, 0, 0, 0));
      reset = 1'b1;
      step(mk("mid_rst_out", 1, 32'h140, 1, 32'h40, 1, 32'h100, 0, 1, 0, 0, 32'h144, 0, 0, 0));
      reset = 1'b0;
      chk("mid_stat_lookups", bp.stat_lookups, 32'd0);
      chk("mid_stat_mispredicts", bp.stat_mispredicts, 32'd0);
      exp_lk = 0;
      exp_mp = 0;
      step(mk("mid_miss_140", 1, 32'h140, 0, 0, 0, 0, 0, 0, 0, 0, 32'h144, 0, 0, 0));
      step(mk("mid_miss_40",  1, 32'h40,  0, 0, 0, 0, 0, 0, 0, 0, 32'h44,  0, 0, 0));
      step(mk("mid_miss_80",  1, 32'h80,  0, 0, 0, 0, 0, 0, 0, 0, 32'h84,  0, 0, 0));
      step(mk("mid_miss_200", 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 32'h204, 0, 0, 0));
      chk("mid_post_lookups", bp.stat_lookups, exp_lk);

      // Mispredict counter wraps modulo 2^32.
      @(posedge clk);
      force dut.r_stat_mispredicts = 32'hFFFF_FFFF;
      #1;
      release dut.r_stat_mispredicts;
      bp.lookup_valid      = 1'b0;
      bp.update_valid      = 1'b1;
      bp.update_pc         = 32'h400;
      bp.update_taken      = 1'b0;
      bp.update_force_jump = 1'b0;
      bp.update_mispredict = 1'b1;
      @(negedge clk);
      #1;
      bp.update_valid = 1'b0;
      chk("wrap_mispredicts", bp.stat_mispredicts, 32'd0);
      chk("wrap_lookups_held", bp.stat_lookups, exp_lk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
